// File: rtl/npc_multicycle_if.sv
// Instruction-fetch bus between the multi-cycle core and instruction memory.
// Request side is valid/ready; the response is a single-beat valid that is always accepted.
interface npc_multicycle_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/npc_multicycle.sv
// Multi-cycle RV32I-subset core: FETCH -> WAIT -> EXEC per instruction, commit trace one cycle later.
// Optional 64-bit cycle/instret counters are built only when NPC_PERF_CNT_EN is defined.
module npc_multicycle #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000,
  parameter int              NR_REGS         = 32,
  parameter bit              HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  npc_multicycle_if.master   imem,
  output logic [XLEN-1:0]    pc,
  output logic               commit_valid,
  output logic [XLEN-1:0]    commit_pc,
  output logic [31:0]        commit_inst,
  output logic               commit_wen,
  output logic [4:0]         commit_rd,
  output logic [XLEN-1:0]    commit_wdata,
  output logic               halted,
  output logic [XLEN-1:0]    halt_code,
  output logic [63:0]        perf_cycle,
  output logic [63:0]        perf_instret
);
  localparam int AW = $clog2(NR_REGS);
  localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17,
                         OPC_JAL = 7'h6F, OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_SYSTEM = 7'h73;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
  state_t state, state_nx;

  logic [31:0]     ir;
  logic [XLEN-1:0] rf [NR_REGS];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1v, rs2v, imm_i, imm_b, imm_j, imm_u, op_b, alu;

  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign f7    = ir[31:25];
  assign rs1v  = rf[rs1[AW-1:0]];
  assign rs2v  = rf[rs2[AW-1:0]];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign op_b  = (opc == OPC_OP) ? rs2v : imm_i;

  always_comb begin
    alu = '0;
    case (f3)
      3'b000: alu = (opc == OPC_OP && f7[5]) ? rs1v - op_b : rs1v + op_b;
      3'b001: alu = rs1v << op_b[4:0];
      3'b010: alu = {{(XLEN-1){1'b0}}, $signed(rs1v) < $signed(op_b)};
      3'b011: alu = {{(XLEN-1){1'b0}}, rs1v < op_b};
      3'b100: alu = rs1v ^ op_b;
      3'b101: alu = f7[5] ? XLEN'($signed(rs1v) >>> op_b[4:0]) : rs1v >> op_b[4:0];
      3'b110: alu = rs1v | op_b;
      default: alu = rs1v & op_b;
    endcase
  end

  logic            illegal, jump, ebreak, wen, use_rd, use_rs1, use_rs2;
  logic [XLEN-1:0] wdata, npc_raw;

  always_comb begin
    illegal = 1'b0; jump = 1'b0; ebreak = 1'b0; wen = 1'b0;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    wdata = '0; npc_raw = pc + 4;
    case (opc)
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wen = 1'b1; wdata = alu;
        if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wen = 1'b1; wdata = alu;
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) illegal = 1'b1;
      end
      OPC_LUI:   begin use_rd = 1'b1; wen = 1'b1; wdata = imm_u; end
      OPC_AUIPC: begin use_rd = 1'b1; wen = 1'b1; wdata = pc + imm_u; end
      OPC_JAL: begin
        use_rd = 1'b1; wen = 1'b1; wdata = pc + 4; npc_raw = pc + imm_j; jump = 1'b1;
      end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wen = 1'b1; wdata = pc + 4; jump = 1'b1;
        npc_raw = (rs1v + imm_i) & ~XLEN'(1);
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          if ((rs1v == rs2v) ^ f3[0]) begin
            jump = 1'b1; npc_raw = pc + imm_b;
          end
        end else illegal = 1'b1;
      end
      OPC_SYSTEM: if (ir == 32'h0010_0073) ebreak = 1'b1; else illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // RV32E builds reject any register field that names a non-existent register
    if ((use_rd  && {1'b0, rd}  >= 6'(NR_REGS)) ||
        (use_rs1 && {1'b0, rs1} >= 6'(NR_REGS)) ||
        (use_rs2 && {1'b0, rs2} >= 6'(NR_REGS))) illegal = 1'b1;
  end

  logic            misalign, fault, halt_now, rd_we;
  logic [XLEN-1:0] next_pc, code;

  assign misalign = jump && npc_raw[1] && !illegal;
  assign fault    = illegal || misalign;
  assign halt_now = ebreak || (fault && HALT_ON_ILLEGAL);
  assign rd_we    = wen && !fault && (rd != 5'd0);
  assign code     = ebreak ? rf[10] : (misalign ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
  // a halting misaligned jump leaves pc on the faulting instruction
  assign next_pc  = !fault ? npc_raw : ((misalign && HALT_ON_ILLEGAL) ? pc : pc + 4);

  always_comb begin
    state_nx = state;
    imem.imem_req_valid = (state == S_FETCH) && rst;
    imem.imem_req_addr  = pc;
    case (state)
      S_FETCH: if (imem.imem_req_ready) state_nx = S_WAIT;
      S_WAIT:  if (imem.imem_resp_valid) state_nx = S_EXEC;
      S_EXEC:  state_nx = halt_now ? S_HALT : S_FETCH;
      default: state_nx = S_HALT;
    endcase
  end

  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_wen   <= 1'b0;
      commit_rd    <= '0;
      commit_wdata <= '0;
      halt_code    <= '0;
      for (int i = 0; i < NR_REGS; i++) rf[i] <= '0;
    end else begin
      state        <= state_nx;
      commit_valid <= 1'b0;
      if (state == S_WAIT && imem.imem_resp_valid) ir <= imem.imem_resp_data;
      if (state == S_EXEC) begin
        pc           <= next_pc;
        commit_valid <= 1'b1;
        commit_pc    <= pc;
        commit_inst  <= ir;
        commit_wen   <= rd_we;
        commit_rd    <= rd;
        commit_wdata <= rd_we ? wdata : '0;
        if (rd_we) rf[rd[AW-1:0]] <= wdata;
        if (halt_now) halt_code <= code;
      end
    end
  end

`ifdef NPC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle   <= '0;
      perf_instret <= '0;
    end else begin
      perf_cycle <= perf_cycle + 64'd1;
      if (commit_valid) perf_instret <= perf_instret + 64'd1;
    end
  end
`else
  assign perf_cycle   = '0;
  assign perf_instret = '0;
`endif
endmodule

// File: tb/tb_npc_multicycle.sv
// Bench for npc_multicycle: programs loaded from vector tables, commits checked against a queue,
// plus hand sequences for fetch stall, reset-in-WAIT, jumps, misaligned and illegal halts.
module tb_npc_multicycle;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;
  localparam logic [31:0] BASE = 32'h8000_0000, EBRK = 32'h0010_0073;

  npc_multicycle_if #(.XLEN(32)) bus ();
  npc_multicycle_if #(.XLEN(32)) bus_e ();

  logic [31:0] pc, commit_pc, commit_inst, commit_wdata, halt_code;
  logic        commit_valid, commit_wen, halted;
  logic [4:0]  commit_rd;
  logic [63:0] perf_cycle, perf_instret;
  logic [31:0] pc_e, cpc_e, cinst_e, cwd_e, hcode_e;
  logic        cv_e, cwen_e, halted_e;
  logic [4:0]  crd_e;
  logic [63:0] pcyc_e, pret_e;

  npc_multicycle dut (
    .clk(clk), .rst(rst), .imem(bus.master), .pc(pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .halted(halted), .halt_code(halt_code), .perf_cycle(perf_cycle), .perf_instret(perf_instret)
  );

  npc_multicycle #(.NR_REGS(16)) dut_e (
    .clk(clk), .rst(rst), .imem(bus_e.master), .pc(pc_e),
    .commit_valid(cv_e), .commit_pc(cpc_e), .commit_inst(cinst_e),
    .commit_wen(cwen_e), .commit_rd(crd_e), .commit_wdata(cwd_e),
    .halted(halted_e), .halt_code(hcode_e), .perf_cycle(pcyc_e), .perf_instret(pret_e)
  );

  // instruction memory: response arrives the cycle after an accepted request
  logic [31:0] mem [64];
  logic        rdy = 1'b0, resp_en = 1'b1, stale = 1'b0, mvalid = 1'b0;
  logic [31:0] mdata = '0;
  assign bus.imem_req_ready  = rdy;
  assign bus.imem_resp_valid = mvalid | stale;
  assign bus.imem_resp_data  = stale ? EBRK : mdata;
  always @(posedge clk) begin
    mvalid <= resp_en && bus.imem_req_valid && rdy;
    mdata  <= mem[bus.imem_req_addr[7:2]];
  end

  // RV32E core always fetches ADDI x17,x0,1
  logic mv_e = 1'b0;
  assign bus_e.imem_req_ready  = 1'b1;
  assign bus_e.imem_resp_valid = mv_e;
  assign bus_e.imem_resp_data  = 32'h0010_0893;
  always @(posedge clk) mv_e <= bus_e.imem_req_valid;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] v = 12'(imm);
    return {v, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    logic [19:0] v = 20'(imm);
    return {v, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  typedef struct { logic [31:0] inst; logic wen; logic [4:0] rd; logic [31:0] wdata; } vec_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic wen; logic [4:0] rd; logic [31:0] wdata; } cmt_t;

  cmt_t exp_q[$];
  int   ccyc[$];
  int   tests = 0, fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  cmt_t mon_e;
  logic mon_ok;
  always @(negedge clk) begin
    if (rst && commit_valid) begin
      tests++;
      ccyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected: got pc=%h inst=%h expected none", commit_pc, commit_inst);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (commit_pc === mon_e.pc) && (commit_inst === mon_e.inst) && (commit_wen === mon_e.wen) &&
                 (!mon_e.wen || (commit_rd === mon_e.rd && commit_wdata === mon_e.wdata));
        if (!mon_ok) begin
          fails++;
          $display("FAIL commit: got pc=%h inst=%h wen=%b rd=%0d wd=%h expected pc=%h inst=%h wen=%b rd=%0d wd=%h",
                   commit_pc, commit_inst, commit_wen, commit_rd, commit_wdata,
                   mon_e.pc, mon_e.inst, mon_e.wen, mon_e.rd, mon_e.wdata);
        end
      end
    end
  end

  task automatic push(logic [31:0] a, logic [31:0] inst, logic wen, int rd, logic [31:0] wd);
    exp_q.push_back('{a, inst, wen, 5'(rd), wd});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    ccyc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_halt(int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halt_reached", 64'(halted), 64'd1);
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tv[26];
  int   seen;

  initial begin
    tv[0]  = '{enc_i(5, 0, 0, 1, OPIMM),          1'b1, 5'd1,  32'd5};
    tv[1]  = '{enc_i(-7, 1, 0, 2, OPIMM),         1'b1, 5'd2,  32'hFFFF_FFFE};
    tv[2]  = '{enc_i(0, 2, 2, 3, OPIMM),          1'b1, 5'd3,  32'd1};
    tv[3]  = '{enc_i(5, 2, 3, 4, OPIMM),          1'b1, 5'd4,  32'd0};
    tv[4]  = '{enc_i(32'hF0, 1, 4, 5, OPIMM),     1'b1, 5'd5,  32'hF5};
    tv[5]  = '{enc_i(-16, 1, 6, 6, OPIMM),        1'b1, 5'd6,  32'hFFFF_FFF5};
    tv[6]  = '{enc_i(32'h7F, 2, 7, 7, OPIMM),     1'b1, 5'd7,  32'h7E};
    tv[7]  = '{enc_i(31, 1, 1, 8, OPIMM),         1'b1, 5'd8,  32'h8000_0000};
    tv[8]  = '{enc_i(4, 2, 5, 9, OPIMM),          1'b1, 5'd9,  32'h0FFF_FFFF};
    tv[9]  = '{enc_i(32'h401, 2, 5, 11, OPIMM),   1'b1, 5'd11, 32'hFFFF_FFFF};
    tv[10] = '{enc_r(0, 2, 1, 0, 12),             1'b1, 5'd12, 32'd3};
    tv[11] = '{enc_r(32, 2, 1, 0, 13),            1'b1, 5'd13, 32'd7};
    tv[12] = '{enc_r(0, 5, 1, 1, 14),             1'b1, 5'd14, 32'h00A0_0000};
    tv[13] = '{enc_r(0, 1, 2, 2, 15),             1'b1, 5'd15, 32'd1};
    tv[14] = '{enc_r(0, 1, 2, 3, 16),             1'b1, 5'd16, 32'd0};
    tv[15] = '{enc_r(0, 2, 1, 4, 17),             1'b1, 5'd17, 32'hFFFF_FFFB};
    tv[16] = '{enc_r(0, 7, 1, 6, 18),             1'b1, 5'd18, 32'h7F};
    tv[17] = '{enc_r(0, 6, 2, 7, 19),             1'b1, 5'd19, 32'hFFFF_FFF4};
    tv[18] = '{enc_r(0, 1, 8, 5, 20),             1'b1, 5'd20, 32'h0400_0000};
    tv[19] = '{enc_r(32, 1, 8, 5, 21),            1'b1, 5'd21, 32'hFC00_0000};
    tv[20] = '{enc_u(32'h12345, 22, LUI),         1'b1, 5'd22, 32'h1234_5000};
    tv[21] = '{enc_u(1, 23, AUIPC),               1'b1, 5'd23, 32'h8000_1054};
    tv[22] = '{enc_i(1, 1, 0, 0, OPIMM),          1'b0, 5'd0,  32'd0};
    tv[23] = '{enc_r(0, 0, 0, 0, 24),             1'b1, 5'd24, 32'd0};
    tv[24] = '{enc_i(32'h2A, 0, 0, 10, OPIMM),    1'b1, 5'd10, 32'h2A};
    tv[25] = '{EBRK,                              1'b0, 5'd0,  32'd0};
    for (int i = 0; i < 64; i++) mem[i] = (i < 26) ? tv[i].inst : 32'hFFFF_FFFF;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'(BASE));
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_halt_code", 64'(halt_code), 64'd0);

    // reset while waiting for a response that never comes
    resp_en = 1'b0; rdy = 1'b1; rst = 1'b1;
    check("first_addr", 64'(bus.imem_req_addr), 64'(BASE));
    @(negedge clk);
    check("wait_no_req", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_wait_req", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk);
    rdy = 1'b0; stale = 1'b1; rst = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    check("stale_ignored_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {31'd0, 1'b1, BASE});
    check("perf_instret_restart", perf_instret, 64'd0);
    resp_en = 1'b1;
    for (int i = 0; i < 26; i++) push(BASE + 32'(i * 4), tv[i].inst, tv[i].wen, tv[i].rd, tv[i].wdata);

    // fetch stalled by ready low
    for (int i = 0; i < 4; i++) begin
      check("stall_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {31'd0, 1'b1, BASE});
      @(negedge clk);
    end
    rdy = 1'b1;
    run_until_halt(400);
    check("ebreak_halt_code", 64'(halt_code), 64'h2A);
    if (ccyc.size() >= 2) check("commit_spacing", 64'(ccyc[1] - ccyc[0]), 64'd3);
    else check("commit_count", 64'(ccyc.size()), 64'd26);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.imem_req_valid) seen++;
    end
    check("halt_no_req", 64'(seen), 64'd0);
    check("halt_sticky", 64'(halted), 64'd1);
    check("rv32e_illegal_halted", 64'(halted_e), 64'd1);
    check("rv32e_halt_code", 64'(hcode_e), 64'hFFFF_FFFF);
`ifdef NPC_PERF_CNT_EN
    check("perf_instret", perf_instret, 64'd26);
`else
    check("perf_tied_off", perf_cycle | perf_instret, 64'd0);
`endif

    // jumps, branches, misaligned target
    for (int i = 0; i < 64; i++) mem[i] = enc_i(1, 0, 0, 3, OPIMM);
    mem[0] = enc_j(8, 1);
    mem[2] = enc_i(0, 1, 0, 2, OPIMM);
    mem[3] = enc_b(8, 2, 1, 1);
    mem[4] = enc_b(8, 2, 1, 0);
    mem[6] = enc_i(32'h1D, 1, 0, 1, JALR);
    mem[8] = enc_i(0, 1, 0, 10, OPIMM);
    mem[9] = enc_j(6, 0);
    do_reset();
    push(BASE,          mem[0], 1'b1, 1,  32'h8000_0004);
    push(BASE + 32'h08, mem[2], 1'b1, 2,  32'h8000_0004);
    push(BASE + 32'h0C, mem[3], 1'b0, 0,  32'd0);
    push(BASE + 32'h10, mem[4], 1'b0, 0,  32'd0);
    push(BASE + 32'h18, mem[6], 1'b1, 1,  32'h8000_001C);
    push(BASE + 32'h20, mem[8], 1'b1, 10, 32'h8000_001C);
    push(BASE + 32'h24, mem[9], 1'b0, 0,  32'd0);
    run_until_halt(200);
    check("misalign_halt_code", 64'(halt_code), 64'hFFFF_FFFE);
    check("misalign_pc_kept", 64'(pc), 64'(BASE + 32'h24));

    // all-ones word is illegal
    mem[0] = 32'hFFFF_FFFF;
    do_reset();
    push(BASE, 32'hFFFF_FFFF, 1'b0, 0, 32'd0);
    run_until_halt(100);
    check("illegal_halt_code", 64'(halt_code), 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/npc_multicycle.md
Name: npc_multicycle

Overview:
- Multi-cycle successor to the single-cycle NPC core.
- Fetches instructions over a valid/ready instruction bus instead of taking a combinational `inst` input.
- Executes an RV32I integer subset: OP-IMM, OP, LUI, AUIPC, JAL, JALR, BEQ, BNE, EBREAK.
- Drives a per-instruction commit trace and a halt status to the simulation harness; holds its own register file.

Parameters:
- XLEN, 32, datapath and register width; only 32 supported.
- RESET_PC, 32'h80000000, PC value loaded on reset.
- NR_REGS, 32, architectural register count; 16 selects RV32E (rs/rd index bit 4 set -> illegal).
- HALT_ON_ILLEGAL, 1, 1: an illegal instruction halts the core; 0: it retires as a NOP.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_resp_valid  in  1  instruction data valid; always accepted.
- imem_resp_data  in  32  fetched instruction.
- pc  out  XLEN  current PC.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_pc  out  XLEN  PC of retired instruction.
- commit_inst  out  32  retired instruction word.
- commit_wen  out  1  retired instruction wrote rd != x0.
- commit_rd  out  5  destination register index.
- commit_wdata  out  XLEN  value written to rd.
- halted  out  1  core stopped (sticky until reset).
- halt_code  out  XLEN  x10 (a0) at EBREAK; 32'hFFFFFFFF on illegal halt.
- perf_cycle  out  64  cycle counter (Optional Feature).
- perf_instret  out  64  retired-instruction counter (Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=FETCH.
  - All commit_* outputs, halted, halt_code, imem_req_valid = 0.
  - Registers x1..xN-1 = 0. x0 reads 0 always and its writes are dropped.
- States:
  - FETCH: imem_req_valid=1, addr=pc. When imem_req_ready=1 -> WAIT. Valid stays high, address stable, until ready.
  - WAIT: imem_req_valid=0. When imem_resp_valid=1, latch imem_resp_data into the instruction register -> EXEC. A response arriving in the same cycle as the accept is not possible; the earliest response is the cycle after the accept.
  - EXEC (exactly one cycle):
    - Decode, read rs1/rs2, ALU, write back rd at the clock edge.
    - pc <= next_pc.
    - commit_* valid on the cycle after EXEC, as a one-cycle pulse.
    - Next state FETCH, or HALT.
  - HALT: no requests issued; pc frozen; halted=1; exits only on reset.
- Latency: minimum 3 cycles per instruction (FETCH, WAIT, EXEC) with ready and resp returned at the earliest opportunity.
- next_pc rules:
  - pc+4 by default.
  - JAL: pc+J-imm.
  - JALR: (rs1+I-imm) & ~1.
  - Taken BEQ/BNE: pc+B-imm.
  - All arithmetic is modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0.
- Link value: JAL/JALR write pc+4 to rd. rd==rs1 for JALR uses the old rs1 value.
- ALU ops:
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - Shift amount is the low 5 bits of the operand.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned.
- EBREAK (32'h00100073):
  - Retires with commit_wen=0; halt_code=x10; then HALT.
- Illegal encodings: any opcode/funct3/funct7 not listed, or rd/rs index >= NR_REGS.
  - HALT_ON_ILLEGAL=1: retire with commit_wen=0, halt_code=32'hFFFFFFFF, HALT.
  - HALT_ON_ILLEGAL=0: NOP, pc+4.
- Misaligned target (next_pc[1]=1 after a jump or branch):
  - Treated as illegal with halt_code=32'hFFFFFFFE.
  - The pc register keeps the faulting instruction's PC.
- Reset mid-transaction: a pending request or response is abandoned. A response that arrives after reset release while in FETCH is ignored.

Optional Feature:
- Macro: NPC_PERF_CNT_EN.
- Defined:
  - perf_cycle increments every clock after reset release, including while in HALT.
  - perf_instret increments on each commit_valid.
  - Both reset to 0, are 64-bit, and wrap silently.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then a memory with ready=1 and response one cycle later, serving ADDI x1,x0,5 / ADDI x2,x1,-7:
  - first imem_req_addr=32'h80000000;
  - commits x1=5, then x2=32'hFFFFFFFE;
  - commit pulses 3 cycles apart.
- ready held low for 4 cycles in FETCH -> imem_req_valid and addr stay stable for all 4 cycles; no state advance.
- JAL x1,+8 at 32'h80000000 -> x1=32'h80000004; next fetch addr 32'h80000008. BNE with x1==x2 -> not taken, pc+4.
- x10=32'h2A, then EBREAK:
  - commit_wen=0, halted=1, halt_code=32'h2A;
  - no further imem_req_valid for 20 cycles.
- Instruction 32'hFFFFFFFF with HALT_ON_ILLEGAL=1 -> halt_code=32'hFFFFFFFF. NR_REGS=16 with ADDI x17 -> illegal halt.
- Assert rst while in WAIT, then release:
  - pc=32'h80000000;
  - stale resp_valid ignored;
  - refetch of the first instruction;
  - with NPC_PERF_CNT_EN, perf_instret restarts at 0.
